// File: rtl/irq_priority_arbiter.sv
// Interrupt request arbiter: latches rising edges into a pending register, then
// presents one unmasked pending line (fixed or rotating priority) until the CPU acks it.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// ST_IDLE  | no grant presented; picks a candidate whenever one is pending
// ST_GRANT | o_valid=1, o_irq_id frozen until ack or clear_all
module irq_priority_arbiter #(
    parameter int NrOfInputBits  = 8,
    parameter int NrOfSelectBits = 3,
    parameter bit RoundRobin     = 1'b0
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [NrOfInputBits-1:0]  i_irq_in,
    input  logic [NrOfInputBits-1:0]  i_irq_mask,
    input  logic                      i_ack,
    input  logic                      i_clear_all,
    output logic                      o_valid,
    output logic [NrOfSelectBits-1:0] o_irq_id,
    output logic [NrOfInputBits-1:0]  o_pending
);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t                    r_state;
    logic [NrOfInputBits-1:0]  r_pending;
    logic [NrOfInputBits-1:0]  r_irq_prev;
    logic                      r_valid;
    logic [NrOfSelectBits-1:0] r_irq_id;
    logic [NrOfSelectBits-1:0] r_last;

    logic [NrOfInputBits-1:0]  w_rise;
    logic [NrOfInputBits-1:0]  w_cand;
    logic [NrOfInputBits-1:0]  w_ackclr;
    logic [NrOfSelectBits-1:0] w_sel;
    logic                      w_any;
    int                        w_start;
    int                        w_dist;
    int                        w_best;

    assign w_rise   = i_irq_in & ~r_irq_prev;
    assign w_cand   = r_pending & ~i_irq_mask;
    assign w_any    = |w_cand;
    assign w_ackclr = (r_state == ST_GRANT && i_ack)
                      ? (NrOfInputBits'(1) << r_irq_id) : '0;

    // Each line gets a distance from the scan start (downward, wrapping);
    // the smallest distance wins. Fixed priority is simply a start of N-1.
    always_comb begin
        w_sel   = '0;
        w_best  = NrOfInputBits;
        w_dist  = 0;
        w_start = NrOfInputBits - 1;
        if (RoundRobin && r_last != '0) begin
            w_start = int'(r_last) - 1;
        end
        for (int i = 0; i < NrOfInputBits; i++) begin
            w_dist = w_start - i;
            if (w_dist < 0) begin
                w_dist = w_dist + NrOfInputBits;
            end
            if (w_cand[i] && w_dist < w_best) begin
                w_best = w_dist;
                w_sel  = NrOfSelectBits'(i);
            end
        end
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state    <= ST_IDLE;
            r_pending  <= '0;
            r_irq_prev <= '0;
            r_valid    <= 1'b0;
            r_irq_id   <= '0;
            r_last     <= '0;
        end else begin
            r_irq_prev <= i_irq_in;
            if (i_clear_all) begin
                r_pending <= '0;
                r_valid   <= 1'b0;
                r_state   <= ST_IDLE;
            end else begin
                // A fresh rise on the acked line re-arms it in the same cycle.
                r_pending <= (r_pending & ~w_ackclr) | w_rise;
                case (r_state)
                    ST_IDLE: begin
                        if (w_any) begin
                            r_irq_id <= w_sel;
                            r_last   <= w_sel;
                            r_valid  <= 1'b1;
                            r_state  <= ST_GRANT;
                        end
                    end
                    ST_GRANT: begin
                        if (i_ack) begin
                            r_valid <= 1'b0;
                            r_state <= ST_IDLE;
                        end
                    end
                    default: begin
                        r_valid <= 1'b0;
                        r_state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign o_valid   = r_valid;
    assign o_irq_id  = r_irq_id;
    assign o_pending = r_pending;

endmodule
